// File: rtl/l2_read_arbiter.sv
// Shares one L2 read port between iCache line refills and dCache miss reads.
// Round-robin grant into a single request register; responses are steered by the ID source bit.
module l2_read_arbiter #(
    parameter int PADDR_W    = 40,
    parameter int ID_W       = 4,
    parameter int DATA_W     = 256,
    parameter int MAX_DC_OUT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               ic_req_valid_i,
    input  logic [PADDR_W-1:0] ic_req_paddr_i,
    output logic               ic_resp_valid_o,
    output logic [DATA_W-1:0]  ic_resp_data_o,

    input  logic               dc_req_valid_i,
    output logic               dc_req_ready_o,
    input  logic [PADDR_W-1:0] dc_req_addr_i,
    input  logic [ID_W-1:0]    dc_req_id_i,
    output logic               dc_resp_valid_o,
    input  logic               dc_resp_ready_i,
    output logic [DATA_W-1:0]  dc_resp_data_o,
    output logic [ID_W-1:0]    dc_resp_id_o,
    output logic               dc_resp_last_o,

    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PADDR_W-1:0] mem_req_addr_o,
    output logic [ID_W:0]      mem_req_id_o,
    input  logic               mem_resp_valid_i,
    output logic               mem_resp_ready_o,
    input  logic [DATA_W-1:0]  mem_resp_data_i,
    input  logic [ID_W:0]      mem_resp_id_i,
    input  logic               mem_resp_last_i
);

    localparam int CNT_W = $clog2(MAX_DC_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DC_OUT);

    localparam logic [1:0] IC_IDLE = 2'd0;
    localparam logic [1:0] IC_PEND = 2'd1;
    localparam logic [1:0] IC_WAIT = 2'd2;

    logic [1:0]         ic_state_q, ic_state_d;
    logic [PADDR_W-1:0] ic_addr_q, ic_addr_d;
    logic               def_valid_q, def_valid_d;
    logic [PADDR_W-1:0] def_addr_q, def_addr_d;
    logic               rr_dc_q, rr_dc_d;
    logic [CNT_W-1:0]   dc_cnt_q, dc_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [PADDR_W-1:0] out_addr_q, out_addr_d;
    logic [ID_W:0]      out_id_q, out_id_d;

    logic out_load;
    logic ic_cand;
    logic dc_cand;
    logic ic_grant;
    logic dc_grant;
    logic resp_is_dc;
    logic ic_resp_hs;
    logic dc_last_hs;

    // Saturating up/down step; simultaneous increment and decrement cancel.
    function automatic logic [CNT_W-1:0] cnt_step(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            if (cnt < CNT_MAX) nxt = cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) nxt = cnt - CNT_W'(1);
        end
        return nxt;
    endfunction

    always_comb begin
        out_load   = !out_valid_q || mem_req_ready_i;
        ic_cand    = (ic_state_q == IC_PEND);
        dc_cand    = dc_req_valid_i && (dc_cnt_q < CNT_MAX);
        dc_grant   = !rst_i && out_load && dc_cand && (!ic_cand || rr_dc_q);
        ic_grant   = !rst_i && out_load && ic_cand && !dc_grant;
        resp_is_dc = mem_resp_id_i[ID_W];
        ic_resp_hs = !rst_i && mem_resp_valid_i && !resp_is_dc;
        dc_last_hs = !rst_i && mem_resp_valid_i && resp_is_dc && dc_resp_ready_i && mem_resp_last_i;
    end

    // iCache request tracking, including the one-entry deferred slot used while a refill is in flight.
    always_comb begin
        ic_state_d  = ic_state_q;
        ic_addr_d   = ic_addr_q;
        def_valid_d = def_valid_q;
        def_addr_d  = def_addr_q;
        case (ic_state_q)
            IC_IDLE: begin
                if (ic_req_valid_i) begin
                    ic_state_d = IC_PEND;
                    ic_addr_d  = ic_req_paddr_i;
                end
            end
            IC_PEND: begin
                if (ic_grant) begin
                    ic_state_d = IC_WAIT;
                    if (ic_req_valid_i) begin
                        def_valid_d = 1'b1;
                        def_addr_d  = ic_req_paddr_i;
                    end
                end else if (ic_req_valid_i) begin
                    ic_addr_d = ic_req_paddr_i;
                end
            end
            IC_WAIT: begin
                if (ic_resp_hs) begin
                    def_valid_d = 1'b0;
                    if (ic_req_valid_i) begin
                        ic_state_d = IC_PEND;
                        ic_addr_d  = ic_req_paddr_i;
                    end else if (def_valid_q) begin
                        ic_state_d = IC_PEND;
                        ic_addr_d  = def_addr_q;
                    end else begin
                        ic_state_d = IC_IDLE;
                    end
                end else if (ic_req_valid_i) begin
                    def_valid_d = 1'b1;
                    def_addr_d  = ic_req_paddr_i;
                end
            end
            default: begin
                ic_state_d  = IC_IDLE;
                def_valid_d = 1'b0;
            end
        endcase
    end

    // Request register stage: grant in cycle N appears on the L2 port in cycle N+1.
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_id_d    = out_id_q;
        rr_dc_d     = rr_dc_q;
        if (out_load) begin
            out_valid_d = ic_grant || dc_grant;
            if (ic_grant) begin
                out_addr_d = ic_addr_q;
                out_id_d   = '0;
            end else if (dc_grant) begin
                out_addr_d = dc_req_addr_i;
                out_id_d   = {1'b1, dc_req_id_i};
            end
        end
        if (ic_grant) begin
            rr_dc_d = 1'b1;
        end else if (dc_grant) begin
            rr_dc_d = 1'b0;
        end
        dc_cnt_d = cnt_step(dc_cnt_q, dc_grant, dc_last_hs);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ic_state_q  <= IC_IDLE;
            ic_addr_q   <= '0;
            def_valid_q <= 1'b0;
            def_addr_q  <= '0;
            rr_dc_q     <= 1'b0;
            dc_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_id_q    <= '0;
        end else begin
            ic_state_q  <= ic_state_d;
            ic_addr_q   <= ic_addr_d;
            def_valid_q <= def_valid_d;
            def_addr_q  <= def_addr_d;
            rr_dc_q     <= rr_dc_d;
            dc_cnt_q    <= dc_cnt_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_id_q    <= out_id_d;
        end
    end

    // Every output is forced quiet while reset is held, including the combinational response path.
    always_comb begin
        mem_req_valid_o  = out_valid_q && !rst_i;
        mem_req_addr_o   = rst_i ? '0 : out_addr_q;
        mem_req_id_o     = rst_i ? '0 : out_id_q;
        dc_req_ready_o   = dc_grant;
        ic_resp_valid_o  = ic_resp_hs && (ic_state_q == IC_WAIT);
        ic_resp_data_o   = rst_i ? '0 : mem_resp_data_i;
        dc_resp_valid_o  = !rst_i && mem_resp_valid_i && resp_is_dc;
        dc_resp_data_o   = rst_i ? '0 : mem_resp_data_i;
        dc_resp_id_o     = rst_i ? '0 : mem_resp_id_i[ID_W-1:0];
        dc_resp_last_o   = !rst_i && mem_resp_last_i;
        mem_resp_ready_o = !rst_i && (resp_is_dc ? dc_resp_ready_i : 1'b1);
    end

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked cycle by cycle
// against a behavioural model of the arbiter held in this bench.
module tb_l2_read_arbiter;

    localparam int PADDR_W = 40;
    localparam int ID_W    = 4;
    localparam int DATA_W  = 32;
    localparam int MAXO    = 4;

    localparam int MODE_IDLE    = 0;
    localparam int MODE_PENDING = 1;
    localparam int MODE_WAITING = 2;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               ic_req_valid_i;
    logic [PADDR_W-1:0] ic_req_paddr_i;
    logic               ic_resp_valid_o;
    logic [DATA_W-1:0]  ic_resp_data_o;
    logic               dc_req_valid_i;
    logic               dc_req_ready_o;
    logic [PADDR_W-1:0] dc_req_addr_i;
    logic [ID_W-1:0]    dc_req_id_i;
    logic               dc_resp_valid_o;
    logic               dc_resp_ready_i;
    logic [DATA_W-1:0]  dc_resp_data_o;
    logic [ID_W-1:0]    dc_resp_id_o;
    logic               dc_resp_last_o;
    logic               mem_req_valid_o;
    logic               mem_req_ready_i;
    logic [PADDR_W-1:0] mem_req_addr_o;
    logic [ID_W:0]      mem_req_id_o;
    logic               mem_resp_valid_i;
    logic               mem_resp_ready_o;
    logic [DATA_W-1:0]  mem_resp_data_i;
    logic [ID_W:0]      mem_resp_id_i;
    logic               mem_resp_last_i;

    always #5 clk = ~clk;

    l2_read_arbiter #(
        .PADDR_W    (PADDR_W),
        .ID_W       (ID_W),
        .DATA_W     (DATA_W),
        .MAX_DC_OUT (MAXO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ic_req_valid_i   (ic_req_valid_i),
        .ic_req_paddr_i   (ic_req_paddr_i),
        .ic_resp_valid_o  (ic_resp_valid_o),
        .ic_resp_data_o   (ic_resp_data_o),
        .dc_req_valid_i   (dc_req_valid_i),
        .dc_req_ready_o   (dc_req_ready_o),
        .dc_req_addr_i    (dc_req_addr_i),
        .dc_req_id_i      (dc_req_id_i),
        .dc_resp_valid_o  (dc_resp_valid_o),
        .dc_resp_ready_i  (dc_resp_ready_i),
        .dc_resp_data_o   (dc_resp_data_o),
        .dc_resp_id_o     (dc_resp_id_o),
        .dc_resp_last_o   (dc_resp_last_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_addr_o   (mem_req_addr_o),
        .mem_req_id_o     (mem_req_id_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .mem_resp_data_i  (mem_resp_data_i),
        .mem_resp_id_i    (mem_resp_id_i),
        .mem_resp_last_i  (mem_resp_last_i)
    );

    int checks    = 0;
    int errors    = 0;
    int ic_pulses = 0;
    int accepted  = 0;

    // Behavioural model state
    int               m_ic;
    logic [PADDR_W-1:0] m_ic_addr;
    bit               m_def_v;
    logic [PADDR_W-1:0] m_def_addr;
    bit               m_rr_dc;
    bit               m_out_v;
    logic [PADDR_W-1:0] m_out_addr;
    logic [ID_W:0]    m_out_id;
    int               m_cnt;
    bit               e_load, e_ic_win, e_dc_win;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ic       = MODE_IDLE;
        m_ic_addr  = '0;
        m_def_v    = 1'b0;
        m_def_addr = '0;
        m_rr_dc    = 1'b0;
        m_out_v    = 1'b0;
        m_out_addr = '0;
        m_out_id   = '0;
        m_cnt      = 0;
    endtask

    // Compare every output with the model in the middle of the cycle.
    task automatic settle();
        logic from_dc;
        logic exp_icr;
        @(negedge clk);
        from_dc  = mem_resp_id_i[ID_W];
        e_load   = 1'b0;
        e_ic_win = 1'b0;
        e_dc_win = 1'b0;
        if (rst_i) begin
            check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'(0));
            check("rst_mem_req_addr", 64'(mem_req_addr_o), 64'(0));
            check("rst_mem_req_id", 64'(mem_req_id_o), 64'(0));
            check("rst_dc_req_ready", 64'(dc_req_ready_o), 64'(0));
            check("rst_ic_resp_valid", 64'(ic_resp_valid_o), 64'(0));
            check("rst_ic_resp_data", 64'(ic_resp_data_o), 64'(0));
            check("rst_dc_resp_valid", 64'(dc_resp_valid_o), 64'(0));
            check("rst_dc_resp_data", 64'(dc_resp_data_o), 64'(0));
            check("rst_dc_resp_id", 64'(dc_resp_id_o), 64'(0));
            check("rst_dc_resp_last", 64'(dc_resp_last_o), 64'(0));
            check("rst_mem_resp_ready", 64'(mem_resp_ready_o), 64'(0));
        end else begin
            e_load = !m_out_v || mem_req_ready_i;
            if (e_load) begin
                if (m_ic == MODE_PENDING && dc_req_valid_i && m_cnt < MAXO) begin
                    if (m_rr_dc) e_dc_win = 1'b1;
                    else         e_ic_win = 1'b1;
                end else if (m_ic == MODE_PENDING) begin
                    e_ic_win = 1'b1;
                end else if (dc_req_valid_i && m_cnt < MAXO) begin
                    e_dc_win = 1'b1;
                end
            end
            check("dc_req_ready", 64'(dc_req_ready_o), 64'(e_dc_win));
            check("mem_req_valid", 64'(mem_req_valid_o), 64'(m_out_v));
            if (m_out_v) begin
                check("mem_req_addr", 64'(mem_req_addr_o), 64'(m_out_addr));
                check("mem_req_id", 64'(mem_req_id_o), 64'(m_out_id));
            end
            exp_icr = mem_resp_valid_i && !from_dc && (m_ic == MODE_WAITING);
            check("ic_resp_valid", 64'(ic_resp_valid_o), 64'(exp_icr));
            if (exp_icr) check("ic_resp_data", 64'(ic_resp_data_o), 64'(mem_resp_data_i));
            check("dc_resp_valid", 64'(dc_resp_valid_o), 64'(mem_resp_valid_i && from_dc));
            if (mem_resp_valid_i && from_dc) begin
                check("dc_resp_data", 64'(dc_resp_data_o), 64'(mem_resp_data_i));
                check("dc_resp_id", 64'(dc_resp_id_o), 64'(mem_resp_id_i[ID_W-1:0]));
                check("dc_resp_last", 64'(dc_resp_last_o), 64'(mem_resp_last_i));
            end
            check("mem_resp_ready", 64'(mem_resp_ready_o), 64'(from_dc ? dc_resp_ready_i : 1'b1));
        end
        if (ic_resp_valid_o) ic_pulses++;
    endtask

    // Advance the model across the rising edge using the inputs held this cycle.
    task automatic advance();
        logic pulse, from_dc, ic_back, dc_done;
        @(posedge clk);
        if (rst_i) begin
            model_reset();
        end else begin
            pulse   = ic_req_valid_i;
            from_dc = mem_resp_id_i[ID_W];
            ic_back = mem_resp_valid_i && !from_dc;
            dc_done = mem_resp_valid_i && from_dc && dc_resp_ready_i && mem_resp_last_i;
            if (e_dc_win && !dc_done) m_cnt = m_cnt + 1;
            else if (dc_done && !e_dc_win && m_cnt > 0) m_cnt = m_cnt - 1;
            if (e_load) begin
                m_out_v = e_ic_win || e_dc_win;
                if (e_ic_win) begin
                    m_out_addr = m_ic_addr;
                    m_out_id   = '0;
                end else if (e_dc_win) begin
                    m_out_addr = dc_req_addr_i;
                    m_out_id   = {1'b1, dc_req_id_i};
                end
            end
            if (e_ic_win) m_rr_dc = 1'b1;
            else if (e_dc_win) m_rr_dc = 1'b0;
            if (m_ic == MODE_IDLE) begin
                if (pulse) begin
                    m_ic      = MODE_PENDING;
                    m_ic_addr = ic_req_paddr_i;
                end
            end else if (m_ic == MODE_PENDING) begin
                if (e_ic_win) begin
                    m_ic = MODE_WAITING;
                    if (pulse) begin
                        m_def_v    = 1'b1;
                        m_def_addr = ic_req_paddr_i;
                    end
                end else if (pulse) begin
                    m_ic_addr = ic_req_paddr_i;
                end
            end else begin
                if (ic_back) begin
                    if (pulse) begin
                        m_ic      = MODE_PENDING;
                        m_ic_addr = ic_req_paddr_i;
                    end else if (m_def_v) begin
                        m_ic      = MODE_PENDING;
                        m_ic_addr = m_def_addr;
                    end else begin
                        m_ic = MODE_IDLE;
                    end
                    m_def_v = 1'b0;
                end else if (pulse) begin
                    m_def_v    = 1'b1;
                    m_def_addr = ic_req_paddr_i;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        ic_req_valid_i   = 1'b0;
        ic_req_paddr_i   = '0;
        dc_req_valid_i   = 1'b0;
        dc_req_addr_i    = '0;
        dc_req_id_i      = '0;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        mem_resp_id_i    = '0;
        mem_resp_last_i  = 1'b0;
        dc_resp_ready_i  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        // Single iCache refill, two-cycle request latency
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h100;
        tick();
        ic_req_valid_i = 1'b0;
        tick();
        settle();
        check("t41_req_valid", 64'(mem_req_valid_o), 64'(1));
        check("t41_req_addr", 64'(mem_req_addr_o), 64'h100);
        check("t41_req_id", 64'(mem_req_id_o), 64'h00);
        advance();
        mem_resp_valid_i = 1'b1; mem_resp_id_i = 5'h00; mem_resp_data_i = 32'hCAFE0001;
        settle();
        check("t41_ic_resp_valid", 64'(ic_resp_valid_o), 64'(1));
        check("t41_ic_resp_data", 64'(ic_resp_data_o), 64'hCAFE0001);
        advance();
        mem_resp_valid_i = 1'b0;
        tick();

        // Simultaneous iCache and dCache from reset, then alternation
        do_reset();
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h300;
        tick();
        ic_req_valid_i = 1'b0;
        dc_req_valid_i = 1'b1; dc_req_addr_i = 40'h1000; dc_req_id_i = 4'h3;
        settle();
        check("t42_dc_ready_first", 64'(dc_req_ready_o), 64'(0));
        advance();
        settle();
        check("t42_first_id", 64'(mem_req_id_o), 64'h00);
        check("t42_first_addr", 64'(mem_req_addr_o), 64'h300);
        check("t42_dc_ready_second", 64'(dc_req_ready_o), 64'(1));
        advance();
        dc_req_valid_i = 1'b0;
        settle();
        check("t42_second_id", 64'(mem_req_id_o), 64'h13);
        advance();
        mem_resp_valid_i = 1'b1; mem_resp_id_i = 5'h00; mem_resp_data_i = 32'h1111;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h340;
        tick();
        mem_resp_valid_i = 1'b0; ic_req_valid_i = 1'b0;
        dc_req_valid_i = 1'b1; dc_req_addr_i = 40'h2000; dc_req_id_i = 4'h7;
        settle();
        check("t42_alt_dc_wait", 64'(dc_req_ready_o), 64'(0));
        advance();
        settle();
        check("t42_alt_ic_addr", 64'(mem_req_addr_o), 64'h340);
        check("t42_alt_dc_ready", 64'(dc_req_ready_o), 64'(1));
        advance();
        dc_req_valid_i = 1'b0;
        settle();
        check("t42_alt_dc_id", 64'(mem_req_id_o), 64'h17);
        advance();

        // Outstanding dCache limit
        do_reset();
        accepted = 0;
        dc_req_valid_i = 1'b1; dc_req_addr_i = 40'h4000;
        for (int i = 0; i < 6; i++) begin
            dc_req_id_i = 4'(i);
            settle();
            if (dc_req_ready_o) accepted++;
            advance();
        end
        check("t43_accepted", 64'(accepted), 64'(4));
        mem_resp_valid_i = 1'b1; mem_resp_id_i = 5'h10; mem_resp_last_i = 1'b1;
        mem_resp_data_i = 32'hD00D;
        settle();
        check("t43_ready_at_last", 64'(dc_req_ready_o), 64'(0));
        check("t43_dc_resp_valid", 64'(dc_resp_valid_o), 64'(1));
        advance();
        mem_resp_valid_i = 1'b0; mem_resp_last_i = 1'b0;
        settle();
        check("t43_ready_after_last", 64'(dc_req_ready_o), 64'(1));
        advance();
        dc_req_valid_i = 1'b0;

        // Back-pressure on the L2 request port
        do_reset();
        dc_req_valid_i = 1'b1; dc_req_addr_i = 40'hABC; dc_req_id_i = 4'h5;
        tick();
        dc_req_addr_i = 40'hDEF; dc_req_id_i = 4'h6; mem_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t44_hold_valid", 64'(mem_req_valid_o), 64'(1));
            check("t44_hold_addr", 64'(mem_req_addr_o), 64'hABC);
            check("t44_hold_id", 64'(mem_req_id_o), 64'h15);
            check("t44_no_grant", 64'(dc_req_ready_o), 64'(0));
            advance();
        end
        mem_req_ready_i = 1'b1;
        settle();
        check("t44_release_grant", 64'(dc_req_ready_o), 64'(1));
        advance();
        dc_req_valid_i = 1'b0;
        settle();
        check("t44_next_addr", 64'(mem_req_addr_o), 64'hDEF);
        check("t44_next_id", 64'(mem_req_id_o), 64'h16);
        advance();

        // Deferred iCache request while a refill is outstanding
        do_reset();
        ic_pulses = 0;
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h200;
        tick();
        ic_req_valid_i = 1'b0;
        tick();
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h240;
        tick();
        ic_req_valid_i = 1'b0;
        tick();
        mem_resp_valid_i = 1'b1; mem_resp_id_i = 5'h00; mem_resp_data_i = 32'hA1;
        tick();
        mem_resp_valid_i = 1'b0;
        tick();
        settle();
        check("t45_deferred_valid", 64'(mem_req_valid_o), 64'(1));
        check("t45_deferred_addr", 64'(mem_req_addr_o), 64'h240);
        advance();
        mem_resp_valid_i = 1'b1; mem_resp_data_i = 32'hA2;
        tick();
        mem_resp_data_i = 32'hA3;
        tick();
        mem_resp_valid_i = 1'b0;
        tick();
        check("t45_ic_pulses", 64'(ic_pulses), 64'(2));

        // Reset in the middle of traffic
        do_reset();
        ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h400;
        tick();
        ic_req_valid_i = 1'b0;
        dc_req_valid_i = 1'b1; dc_req_addr_i = 40'h10; dc_req_id_i = 4'h1;
        tick();
        tick();
        dc_req_id_i = 4'h2;
        tick();
        rst_i = 1'b1;
        mem_resp_valid_i = 1'b1; mem_resp_id_i = 5'h1F; mem_resp_last_i = 1'b1;
        mem_resp_data_i = 32'h5A5A5A5A;
        tick();
        rst_i = 1'b0;
        dc_req_valid_i = 1'b0;
        mem_resp_id_i = 5'h00; mem_resp_last_i = 1'b0;
        settle();
        check("t46_no_ic_pulse", 64'(ic_resp_valid_o), 64'(0));
        check("t46_req_idle", 64'(mem_req_valid_o), 64'(0));
        advance();
        mem_resp_valid_i = 1'b0;
        dc_req_valid_i = 1'b1;
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            if (dc_req_ready_o) accepted++;
            advance();
        end
        check("t46_counter_cleared", 64'(accepted), 64'(4));

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_i            = ($urandom_range(0, 299) == 0);
            ic_req_valid_i   = ($urandom_range(0, 3) == 0);
            ic_req_paddr_i   = PADDR_W'({$urandom, $urandom});
            dc_req_valid_i   = ($urandom_range(0, 1) == 1);
            dc_req_addr_i    = PADDR_W'({$urandom, $urandom});
            dc_req_id_i      = ID_W'($urandom);
            mem_req_ready_i  = ($urandom_range(0, 3) != 0);
            dc_resp_ready_i  = ($urandom_range(0, 3) != 0);
            mem_resp_valid_i = ($urandom_range(0, 2) == 0);
            mem_resp_data_i  = DATA_W'($urandom);
            mem_resp_last_i  = ($urandom_range(0, 1) == 1);
            if (m_cnt > 0 && $urandom_range(0, 1) == 1)
                mem_resp_id_i = {1'b1, ID_W'($urandom)};
            else
                mem_resp_id_i = '0;
            tick();
        end
        rst_i = 1'b0;
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
